rr_resource_arbiter: RTL and testbench
======================================

Name: rr_resource_arbiter

Overview:
Round-robin arbiter that shares one datapath resource among up to NUM_REQ requesters. Issues a registered one-hot grant vector, 32 bits wide, and a binary owner index. Ownership is held until the owner drops its request. The grant vector drives the one-hot select input of the downstream resource mux. grantIndex feeds control and status logic directly.

Parameters:
NUM_REQ, 24, number of requesters; legal range 2..31.
MAX_HOLD, 16, maximum grant length in cycles when ARB_HOLD_LIMIT_EN is defined; legal range 1..255.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  level request per requester; held high for the whole ownership.
grant  output  32  one-hot owner; bits NUM_REQ..31 are always 0; all-zero when there is no owner.
grantIndex  output  5  binary index of the owner; 5'd31 when there is no owner.
grantValid  output  1  high while grant is non-zero.
grantCount  output  16  saturating count of grants issued since reset.

Behaviour:
- Reset values (asynchronous): state IDLE, grant=0, grantIndex=31, grantValid=0, pointer=0, holdCnt=0, grantCount=0.
- All outputs are registered. grant, grantIndex and grantValid always change in the same cycle.
- States: IDLE and OWN.
- IDLE, no req bit set: stay in IDLE; outputs stay idle.
- IDLE, any req bit set: select the first set bit searching upward from pointer, wrapping from NUM_REQ-1 to 0.
  - Next cycle: state OWN; grant = 1<<sel; grantIndex = sel; grantValid = 1; grantCount++ (saturates at 16'hFFFF); holdCnt = 1.
  - Latency is 1 cycle from req sampled high to grant.
- OWN, req[owner] still high: stay in OWN; holdCnt++ (saturates at 255).
  - Other requests have no effect; there is no preemption.
- OWN, req[owner] sampled low: next cycle state IDLE; grant=0; grantIndex=31; grantValid=0; pointer = (owner+1) mod NUM_REQ.
  - This guarantees at least one idle cycle between consecutive grants (bus turnaround).
- Requester just released and it is the only one still requesting: it is granted again after the idle cycle.
- Fairness: with all requests set and each owner releasing after k cycles, requester order is 0,1,...,NUM_REQ-1,0,...
  - Worst-case wait is (NUM_REQ-1)*(maxHold+1)+1 cycles.
- req bits change during the idle cycle: arbitration uses the values sampled in that IDLE cycle.
- pointer wraps: after owner NUM_REQ-1 releases, pointer becomes 0.
- Reset asserted mid-ownership: grant drops immediately (asynchronously). After resetn deasserts, arbitration restarts from pointer 0. There is no memory of the previous owner.
- Requester raises req and drops it before being granted: no grant is issued if the bit is low in the arbitration cycle.
- Requester drops req in the same cycle its grant appears: ownership lasts exactly 1 cycle, then IDLE.
- The design must not contain latches. Any leftover combinational select logic must assign a default on every path.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: in OWN, when holdCnt reaches MAX_HOLD with req[owner] still high, the arbiter forces a release.
  - Next cycle: state IDLE; grant=0; grantValid=0; grantIndex=31; pointer = owner+1.
  - The forced-off owner re-competes normally; its req staying high is legal.
- Not defined: ownership is unlimited. holdCnt still counts but has no effect; synthesis may prune it. MAX_HOLD is ignored.

Test Plan:
1. Reset: hold resetn=0 with req=24'hFFFFFF -> grant=0, grantIndex=31, grantValid=0, grantCount=0. Release reset -> grant=32'h1 and grantIndex=0 one cycle later.
2. Single requester: req[5]=1 at cycle t -> at t+1 grant=32'h20, grantIndex=5, grantCount=1. Drop req[5] at t+4 -> at t+5 grant=0, grantIndex=31.
3. Round robin with wrap: all 24 requests held, each owner releases after 2 cycles -> grantIndex sequence 0,1,...,23,0 with one idle cycle between grants; grantCount=25 after the 25th grant.
4. Pointer skip: pointer=6, req bits 3 and 20 set -> grantIndex=20 next; after its release -> grantIndex=3.
5. Reset mid-grant: owner 9 active, pulse resetn low for 2 cycles mid-cycle -> grant goes to 0 before the next edge; after release, req bits 2 and 9 set -> grantIndex=2.
6. With ARB_HOLD_LIMIT_EN, MAX_HOLD=4: req[0] and req[1] held continuously -> owner 0 for 4 cycles, 1 idle cycle, owner 1 for 4 cycles, 1 idle cycle, owner 0 again. Without the macro -> owner 0 is held indefinitely.

Source files
------------

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter: one owner at a time, held until its request drops, registered outputs.
// Define ARB_HOLD_LIMIT_EN to force a release after MAX_HOLD cycles of continuous ownership.
`timescale 1ns/1ps
module rr_resource_arbiter #(
    parameter int unsigned NUM_REQ  = 24,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    output logic [31:0]        grant,
    output logic [4:0]         grantIndex,
    output logic               grantValid,
    output logic [15:0]        grantCount
);

    typedef enum logic {StIdle, StOwn} state_e;

    localparam logic [4:0] LastIdx = 5'(NUM_REQ - 1);
    localparam logic [4:0] NoOwner = 5'd31;
    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HoldLimitOn = 1'b1;
`else
    localparam bit HoldLimitOn = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] grant_q, grant_d;
    logic [4:0]  index_q, index_d;
    logic        valid_q, valid_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] count_q, count_d;

    logic [31:0] req_ext;
    logic [5:0]  cand;
    logic [4:0]  sel;
    logic        found;
    logic        hold_hit;

    assign req_ext = 32'(req);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        index_d  = index_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        count_d  = count_q;
        cand     = '0;
        sel      = '0;
        found    = 1'b0;
        hold_hit = HoldLimitOn && (hold_q >= HoldMax);

        // First set request at or above the pointer, wrapping at NUM_REQ-1.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = {1'b0, ptr_q} + 6'(i);
            if (cand >= 6'(NUM_REQ)) begin
                cand = cand - 6'(NUM_REQ);
            end
            if (!found && req_ext[cand[4:0]]) begin
                found = 1'b1;
                sel   = cand[4:0];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOwn;
                    grant_d = 32'd1 << sel;
                    index_d = sel;
                    valid_d = 1'b1;
                    hold_d  = 8'd1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            StOwn: begin
                if (!req_ext[index_q] || hold_hit) begin
                    state_d = StIdle;
                    grant_d = '0;
                    index_d = NoOwner;
                    valid_d = 1'b0;
                    ptr_d   = (index_q == LastIdx) ? 5'd0 : index_q + 5'd1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            grant_q <= '0;
            index_q <= NoOwner;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    assign grant      = grant_q;
    assign grantIndex = index_q;
    assign grantValid = valid_q;
    assign grantCount = count_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter with hand-computed expectations.
`timescale 1ns/1ps
module tb_rr_resource_arbiter;

    localparam int NumReq = 24;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [NumReq-1:0] req = '0;
    logic [31:0]       grant;
    logic [4:0]        grantIndex;
    logic              grantValid;
    logic [15:0]       grantCount;

    int n_vec = 0;
    int n_err = 0;

    rr_resource_arbiter #(
        .NUM_REQ  (NumReq),
        .MAX_HOLD (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .grant      (grant),
        .grantIndex (grantIndex),
        .grantValid (grantValid),
        .grantCount (grantCount)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [4:0] hold_seq(input int c);
`ifdef ARB_HOLD_LIMIT_EN
        if (c <= 4) return 5'd0;
        if (c == 5) return 5'd31;
        if (c <= 9) return 5'd1;
        if (c == 10) return 5'd31;
        return 5'd0;
`else
        return (c >= 1) ? 5'd0 : 5'd31;
`endif
    endfunction

    initial begin
        // 1: reset with all requests pending
        req = '1;
        tick();
        check_eq("rst_grant", grant, 32'h0);
        check_eq("rst_index", 32'(grantIndex), 32'd31);
        check_eq("rst_valid", 32'(grantValid), 32'd0);
        check_eq("rst_count", 32'(grantCount), 32'd0);
        resetn = 1'b1;
        tick();
        check_eq("rst_first_grant", grant, 32'h1);
        check_eq("rst_first_index", 32'(grantIndex), 32'd0);

        // 2: single requester, then 4: pointer skip from 6
        req = '0;
        do_reset();
        req = 24'(1) << 5;
        tick();
        check_eq("single_grant", grant, 32'h20);
        check_eq("single_index", 32'(grantIndex), 32'd5);
        check_eq("single_count", 32'(grantCount), 32'd1);
        tick();
        tick();
        check_eq("single_hold", grant, 32'h20);
        tick();
        req = '0;
        tick();
        check_eq("single_rel_grant", grant, 32'h0);
        check_eq("single_rel_index", 32'(grantIndex), 32'd31);
        check_eq("single_rel_valid", 32'(grantValid), 32'd0);
        req = (24'(1) << 3) | (24'(1) << 20);
        tick();
        check_eq("skip_first", 32'(grantIndex), 32'd20);
        req[20] = 1'b0;
        tick();
        check_eq("skip_idle", 32'(grantValid), 32'd0);
        tick();
        check_eq("skip_wrap", 32'(grantIndex), 32'd3);
        check_eq("skip_wrap_grant", grant, 32'h8);
        req = '0;
        tick();

        // 3: full round robin with wrap, two-cycle ownerships
        do_reset();
        req = '1;
        for (int g = 0; g < 25; g++) begin
            tick();
            check_eq($sformatf("rr_index_%0d", g), 32'(grantIndex), 32'(g % NumReq));
            tick();
            req[g % NumReq] = 1'b0;
            tick();
            check_eq($sformatf("rr_gap_%0d", g), 32'(grantValid), 32'd0);
            req[g % NumReq] = 1'b1;
        end
        check_eq("rr_count", 32'(grantCount), 32'd25);

        // 5: reset pulse while owner 9 is active
        req = '0;
        do_reset();
        req = 24'(1) << 9;
        tick();
        check_eq("mid_owner", 32'(grantIndex), 32'd9);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("mid_async_grant", grant, 32'h0);
        check_eq("mid_async_valid", 32'(grantValid), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #4;
        resetn = 1'b1;
        req = (24'(1) << 2) | (24'(1) << 9);
        tick();
        check_eq("mid_restart", 32'(grantIndex), 32'd2);

        // Short-lived request and one-cycle ownership
        req = '0;
        tick();
        req = 24'(1) << 7;
        #3;
        req = '0;
        tick();
        check_eq("blip_nogrant", 32'(grantValid), 32'd0);
        req = 24'(1) << 4;
        tick();
        check_eq("one_cycle_on", 32'(grantIndex), 32'd4);
        req = '0;
        tick();
        check_eq("one_cycle_off", 32'(grantIndex), 32'd31);

        // 6: hold limit behaviour with requesters 0 and 1 held
        do_reset();
        req = 24'h3;
        for (int c = 1; c <= 11; c++) begin
            tick();
            check_eq($sformatf("hold_c%0d", c), 32'(grantIndex), 32'(hold_seq(c)));
        end
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
